// File: rtl/picorv32_mem_arbiter_if.sv
// PicoRV32 native memory interface bundle.
// The master drives the request fields and the slave answers with ready/rdata.
interface picorv32_mem_arbiter_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-requester arbiter for the PicoRV32 native memory interface.
// Whole transactions from m0/m1 are serialised onto the single downstream port,
// with round-robin or fixed priority and a per-transaction timeout watchdog.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transaction in flight; arbitrate on m0/m1 valid
//   BUSY  | request presented downstream; waiting for s_ready or timeout
//   DONE  | ready pulse issued to the owner; one quiet cycle before IDLE
module picorv32_mem_arbiter #(
   parameter int          FIXED_PRIORITY = 0,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          TIMEOUT_WIDTH  = 16,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   picorv32_mem_arbiter_if.slave   m0,
   picorv32_mem_arbiter_if.slave   m1,
   picorv32_mem_arbiter_if.master  s,
   output logic                    busy,
   output logic                    grant_id,
   output logic                    timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam bit                     TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                   state_q, state_d;
   logic                     last_grant_q, last_grant_d;
   logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
   logic                     busy_q, busy_d;
   logic                     grant_q, grant_d;
   logic                     terr_q, terr_d;

   logic                     s_valid_q, s_valid_d;
   logic                     s_instr_q, s_instr_d;
   logic [31:0]              s_addr_q, s_addr_d;
   logic [31:0]              s_wdata_q, s_wdata_d;
   logic [3:0]               s_wstrb_q, s_wstrb_d;

   logic                     m0_ready_q, m0_ready_d;
   logic [31:0]              m0_rdata_q, m0_rdata_d;
   logic                     m1_ready_q, m1_ready_d;
   logic [31:0]              m1_rdata_q, m1_rdata_d;

   logic                     win;
   logic [31:0]              resp_data;
   logic                     resp_fire;

   // Arbitration winner in IDLE: a lone requester wins, ties go by policy.
   always_comb begin
      win = 1'b0;
      if (m0.valid && m1.valid) begin
         win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
      end else if (m1.valid) begin
         win = 1'b1;
      end
   end

   // Next-state and next-value logic for every registered output.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      grant_d      = grant_q;
      terr_d       = 1'b0;
      s_valid_d    = s_valid_q;
      s_instr_d    = s_instr_q;
      s_addr_d     = s_addr_q;
      s_wdata_d    = s_wdata_q;
      s_wstrb_d    = s_wstrb_q;
      m0_ready_d   = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_ready_d   = 1'b0;
      m1_rdata_d   = m1_rdata_q;
      resp_fire    = 1'b0;
      resp_data    = s.rdata;

      unique case (state_q)
         IDLE: begin
            if (m0.valid || m1.valid) begin
               s_instr_d    = win ? m1.instr : m0.instr;
               s_addr_d     = win ? m1.addr  : m0.addr;
               s_wdata_d    = win ? m1.wdata : m0.wdata;
               s_wstrb_d    = win ? m1.wstrb : m0.wstrb;
               s_valid_d    = 1'b1;
               grant_d      = win;
               last_grant_d = win;
               timer_d      = '0;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            timer_d = timer_q + TIMEOUT_WIDTH'(1);
            // s_ready takes precedence over a coincident watchdog expiry.
            if (s.ready) begin
               resp_fire = 1'b1;
               resp_data = s.rdata;
            end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
               resp_fire = 1'b1;
               resp_data = ERR_RDATA;
               terr_d    = 1'b1;
            end
            if (resp_fire) begin
               s_valid_d = 1'b0;
               state_d   = DONE;
               if (grant_q) begin
                  m1_ready_d = 1'b1;
                  m1_rdata_d = resp_data;
               end else begin
                  m0_ready_d = 1'b1;
                  m0_rdata_d = resp_data;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            s_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; last_grant resets to m1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         timer_q      <= '0;
         busy_q       <= 1'b0;
         grant_q      <= 1'b0;
         terr_q       <= 1'b0;
         s_valid_q    <= 1'b0;
         s_instr_q    <= 1'b0;
         s_addr_q     <= '0;
         s_wdata_q    <= '0;
         s_wstrb_q    <= '0;
         m0_ready_q   <= 1'b0;
         m0_rdata_q   <= '0;
         m1_ready_q   <= 1'b0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         busy_q       <= busy_d;
         grant_q      <= grant_d;
         terr_q       <= terr_d;
         s_valid_q    <= s_valid_d;
         s_instr_q    <= s_instr_d;
         s_addr_q     <= s_addr_d;
         s_wdata_q    <= s_wdata_d;
         s_wstrb_q    <= s_wstrb_d;
         m0_ready_q   <= m0_ready_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_ready_q   <= m1_ready_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign s.valid     = s_valid_q;
   assign s.instr     = s_instr_q;
   assign s.addr      = s_addr_q;
   assign s.wdata     = s_wdata_q;
   assign s.wstrb     = s_wstrb_q;
   assign m0.ready    = m0_ready_q;
   assign m0.rdata    = m0_rdata_q;
   assign m1.ready    = m1_ready_q;
   assign m1.rdata    = m1_rdata_q;
   assign busy        = busy_q;
   assign grant_id    = grant_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter: a round-robin instance with a short
// watchdog driven from a vector table, plus a fixed-priority instance and a
// mid-transaction reset sequence.
module tb_picorv32_mem_arbiter;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   picorv32_mem_arbiter_if rr_m0 ();
   picorv32_mem_arbiter_if rr_m1 ();
   picorv32_mem_arbiter_if rr_s ();
   picorv32_mem_arbiter_if fp_m0 ();
   picorv32_mem_arbiter_if fp_m1 ();
   picorv32_mem_arbiter_if fp_s ();

   logic rr_busy, rr_gid, rr_terr;
   logic fp_busy, fp_gid, fp_terr;

   picorv32_mem_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut_rr (
      .clk(clk), .resetn(resetn), .m0(rr_m0), .m1(rr_m1), .s(rr_s),
      .busy(rr_busy), .grant_id(rr_gid), .timeout_err(rr_terr)
   );

   picorv32_mem_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(8)) dut_fp (
      .clk(clk), .resetn(resetn), .m0(fp_m0), .m1(fp_m1), .s(fp_s),
      .busy(fp_busy), .grant_id(fp_gid), .timeout_err(fp_terr)
   );

   typedef struct {
      logic        m0v;
      logic        m1v;
      logic [3:0]  ws0;
      logic [3:0]  ws1;
      int          wt;     // BUSY cycle (1-based) carrying s_ready; 0 = never
      logic [31:0] srd;
      logic        gid;
      logic        err;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      logic [31:0] a0, a1, d0, d1, exp_rd;
      int          n;
      a0 = 32'h0000_0100 + 32'(i * 16);
      a1 = 32'h8000_0000 + 32'(i * 16);
      d0 = 32'hA0A0_0000 + 32'(i);
      d1 = 32'hB0B0_0000 + 32'(i);
      exp_rd = vt[i].err ? 32'hDEAD_BEEF : vt[i].srd;
      n = (vt[i].wt == 0) ? TO : vt[i].wt;

      @(negedge clk);
      rr_m0.valid = vt[i].m0v; rr_m0.addr = a0; rr_m0.wdata = d0; rr_m0.wstrb = vt[i].ws0; rr_m0.instr = 1'b1;
      rr_m1.valid = vt[i].m1v; rr_m1.addr = a1; rr_m1.wdata = d1; rr_m1.wstrb = vt[i].ws1; rr_m1.instr = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d s_valid", i), 32'(rr_s.valid), 32'd1);
      chk($sformatf("v%0d grant_id", i), 32'(rr_gid), 32'(vt[i].gid));
      chk($sformatf("v%0d s_addr", i), rr_s.addr, vt[i].gid ? a1 : a0);
      chk($sformatf("v%0d s_wdata", i), rr_s.wdata, vt[i].gid ? d1 : d0);
      chk($sformatf("v%0d s_wstrb", i), 32'(rr_s.wstrb), 32'(vt[i].gid ? vt[i].ws1 : vt[i].ws0));
      chk($sformatf("v%0d s_instr", i), 32'(rr_s.instr), 32'(!vt[i].gid));
      chk($sformatf("v%0d busy", i), 32'(rr_busy), 32'd1);

      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         rr_s.ready = (k == vt[i].wt);
         rr_s.rdata = (k == vt[i].wt) ? vt[i].srd : 32'h0BAD_0BAD;
         @(posedge clk); #1;
         if (k < n) begin
            chk($sformatf("v%0d hold k%0d", i, k), 32'(rr_s.valid), 32'd1);
            chk($sformatf("v%0d early ready k%0d", i, k), 32'(rr_m0.ready | rr_m1.ready), 32'd0);
         end
      end
      chk($sformatf("v%0d s_valid drop", i), 32'(rr_s.valid), 32'd0);
      chk($sformatf("v%0d owner ready", i), 32'(vt[i].gid ? rr_m1.ready : rr_m0.ready), 32'd1);
      chk($sformatf("v%0d other ready", i), 32'(vt[i].gid ? rr_m0.ready : rr_m1.ready), 32'd0);
      chk($sformatf("v%0d rdata", i), vt[i].gid ? rr_m1.rdata : rr_m0.rdata, exp_rd);
      chk($sformatf("v%0d timeout_err", i), 32'(rr_terr), 32'(vt[i].err));

      @(negedge clk);
      rr_s.ready = 1'b0;
      rr_m0.valid = 1'b0;
      rr_m1.valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d ready clear", i), 32'(rr_m0.ready | rr_m1.ready), 32'd0);
      chk($sformatf("v%0d terr clear", i), 32'(rr_terr), 32'd0);
      chk($sformatf("v%0d busy clear", i), 32'(rr_busy), 32'd0);
      chk($sformatf("v%0d rdata hold", i), vt[i].gid ? rr_m1.rdata : rr_m0.rdata, exp_rd);
   endtask

   initial begin
      logic found;

      rr_m0.valid = 0; rr_m0.instr = 0; rr_m0.addr = 0; rr_m0.wdata = 0; rr_m0.wstrb = 0;
      rr_m1.valid = 0; rr_m1.instr = 0; rr_m1.addr = 0; rr_m1.wdata = 0; rr_m1.wstrb = 0;
      rr_s.ready = 0; rr_s.rdata = 0;
      fp_m0.valid = 0; fp_m0.instr = 0; fp_m0.addr = 32'h40; fp_m0.wdata = 0; fp_m0.wstrb = 0;
      fp_m1.valid = 0; fp_m1.instr = 0; fp_m1.addr = 32'h80; fp_m1.wdata = 0; fp_m1.wstrb = 0;
      fp_s.ready = 0; fp_s.rdata = 0;

      // m0v m1v ws0 ws1 wt srd gid err ; reset leaves last_grant=1
      vt[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 3, 32'h1122_3344, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 4'h0, 4'h0, 2, 32'h0000_00A1, 1'b1, 1'b0};
      vt[2] = '{1'b1, 1'b1, 4'h0, 4'h0, 2, 32'h0000_00A2, 1'b0, 1'b0};
      vt[3] = '{1'b1, 1'b1, 4'h0, 4'h0, 2, 32'h0000_00A3, 1'b1, 1'b0};
      vt[4] = '{1'b1, 1'b1, 4'h0, 4'h0, 2, 32'h0000_00A4, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 4'h0, 4'h0, 0, 32'h0000_0000, 1'b1, 1'b1};
      vt[6] = '{1'b1, 1'b0, 4'h0, 4'h0, 8, 32'h55AA_55AA, 1'b0, 1'b0};
      vt[7] = '{1'b0, 1'b1, 4'h5, 4'hC, 1, 32'h7777_0001, 1'b1, 1'b0};

      #1;
      chk("rst s_valid", 32'(rr_s.valid), 32'd0);
      chk("rst busy", 32'(rr_busy), 32'd0);
      chk("rst grant_id", 32'(rr_gid), 32'd0);
      chk("rst ready", 32'(rr_m0.ready | rr_m1.ready), 32'd0);
      chk("rst rdata", rr_m0.rdata | rr_m1.rdata, 32'd0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Fixed priority: both valid held, m0 keeps winning.
      @(negedge clk);
      fp_m0.valid = 1'b1;
      fp_m1.valid = 1'b1;
      for (int r = 0; r < 3; r++) begin
         found = 1'b0;
         for (int w = 0; w < 10 && !found; w++) begin
            @(posedge clk); #1;
            found = fp_s.valid;
         end
         chk($sformatf("fp r%0d grant seen", r), 32'(found), 32'd1);
         chk($sformatf("fp r%0d grant_id", r), 32'(fp_gid), 32'd0);
         chk($sformatf("fp r%0d s_addr", r), fp_s.addr, 32'h40);
         @(negedge clk);
         fp_s.ready = 1'b1;
         fp_s.rdata = 32'hF000_0000 + 32'(r);
         @(posedge clk); #1;
         chk($sformatf("fp r%0d m0_ready", r), 32'(fp_m0.ready), 32'd1);
         chk($sformatf("fp r%0d m1_ready", r), 32'(fp_m1.ready), 32'd0);
         chk($sformatf("fp r%0d m0_rdata", r), fp_m0.rdata, 32'hF000_0000 + 32'(r));
         @(negedge clk);
         fp_s.ready = 1'b0;
      end
      fp_m0.valid = 1'b0;
      fp_m1.valid = 1'b0;
      repeat (4) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         run_vec(i);
      end

      // Reset in the middle of a write; afterwards m0 must win the first tie again.
      @(negedge clk);
      rr_m0.valid = 1'b1; rr_m0.addr = 32'h200; rr_m0.wdata = 32'h1234_5678; rr_m0.wstrb = 4'b0011;
      @(posedge clk); #1;
      chk("mid s_wstrb", 32'(rr_s.wstrb), 32'h3);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("mid s_valid", 32'(rr_s.valid), 32'd0);
      chk("mid s_addr", rr_s.addr, 32'd0);
      chk("mid s_wdata", rr_s.wdata, 32'd0);
      chk("mid s_wstrb0", 32'(rr_s.wstrb), 32'd0);
      chk("mid busy", 32'(rr_busy), 32'd0);
      chk("mid grant_id", 32'(rr_gid), 32'd0);
      chk("mid rdata", rr_m0.rdata | rr_m1.rdata, 32'd0);
      rr_m0.valid = 1'b0;
      rr_m0.wstrb = 4'h0;
      @(negedge clk);
      resetn = 1'b1;
      rr_m0.valid = 1'b1;
      rr_m1.valid = 1'b1;
      @(posedge clk); #1;
      chk("post rst s_valid", 32'(rr_s.valid), 32'd1);
      chk("post rst grant_id", 32'(rr_gid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
